// File: rtl/radix4_serial_multiplier.sv
// -----------------------------------------------------------------------------
// radix4_serial_multiplier
//
// Sequential N x N unsigned multiplier. Each RUN clock forms one 2-bit x 2-bit
// digit product and adds it, shifted into place, to a 2N-bit accumulator.
// j (multiplier digit) is the inner counter and i (multiplicand digit) is the
// outer counter. A job takes D*D RUN clocks, where D = N/2.
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset; it takes priority over every transition
//   start  job request, sampled only in IDLE or DONE
//   a, b   operands, captured on the accepting edge
//   busy   high while in RUN (registered)
//   done   one-cycle pulse while in DONE (registered)
//   p      product register; changes only on RUN->DONE or on reset
// -----------------------------------------------------------------------------
module radix4_serial_multiplier #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] p
);

  localparam int D  = N / 2;
  localparam int CW = (D > 1) ? $clog2(D) : 1;
  // The largest shift is 2*(2D-2) = 2N-4, so clog2(2N) bits are enough.
  localparam int SW = $clog2(2 * N);
  localparam logic [CW-1:0] DIGIT_LAST = CW'(D - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_next_s;
  logic            accept_s;
  logic            last_s;
  logic [N-1:0]    ra_r;
  logic [N-1:0]    rb_r;
  logic [2*N-1:0]  acc_r;
  logic [2*N-1:0]  p_r;
  logic [CW-1:0]   i_r;
  logic [CW-1:0]   j_r;
  logic            busy_r;
  logic            done_r;
  logic [1:0]      da_s;
  logic [1:0]      db_s;
  logic [3:0]      q_s;
  logic [SW-1:0]   shamt_s;
  logic [2*N-1:0]  term_s;
  logic [2*N-1:0]  sum_s;

  // 2x2 digit product cell; the result is at most 9 and fits in 4 bits.
  function automatic logic [3:0] digit_mul(input logic [1:0] x, input logic [1:0] y);
    return {2'b00, x} * {2'b00, y};
  endfunction

  // Digit selection and the shifted partial-product add for the current (i, j).
  always_comb begin
    da_s    = ra_r[{i_r, 1'b0} +: 2];
    db_s    = rb_r[{j_r, 1'b0} +: 2];
    q_s     = digit_mul(da_s, db_s);
    shamt_s = SW'({i_r, 1'b0}) + SW'({j_r, 1'b0});
    term_s  = {{(2*N-4){1'b0}}, q_s} << shamt_s;
    sum_s   = acc_r + term_s;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic, the accept strobe and the last-digit strobe.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    last_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = RUN;
          accept_s     = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if ((i_r == DIGIT_LAST) && (j_r == DIGIT_LAST)) begin
          state_next_s = DONE;
          last_s       = 1'b1;
        end else begin
          state_next_s = RUN;
        end
      end
      DONE: begin
        // A request in DONE starts the next job immediately, as it would from IDLE.
        if (start) begin
          state_next_s = RUN;
          accept_s     = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Operand capture, digit counters, accumulator and product register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ra_r  <= '0;
      rb_r  <= '0;
      acc_r <= '0;
      p_r   <= '0;
      i_r   <= '0;
      j_r   <= '0;
    end else if (accept_s) begin
      ra_r  <= a;
      rb_r  <= b;
      acc_r <= '0;
      i_r   <= '0;
      j_r   <= '0;
    end else if (state_r == RUN) begin
      acc_r <= sum_s;
      if (j_r == DIGIT_LAST) begin
        j_r <= '0;
        i_r <= (i_r == DIGIT_LAST) ? '0 : i_r + CW'(1);
      end else begin
        j_r <= j_r + CW'(1);
      end
      // The last digit product goes straight into p, so p is valid together with done.
      if (last_s) begin
        p_r <= sum_s;
      end
    end
  end

  // busy and done come from flops loaded with the decoded next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_next_s == RUN);
      done_r <= (state_next_s == DONE);
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign p    = p_r;

endmodule

// File: tb/tb_radix4_serial_multiplier.sv
// -----------------------------------------------------------------------------
// tb_radix4_serial_multiplier
//
// Directed self-checking bench for an N=8 and an N=4 instance. Expected
// products are pushed to per-instance queues when a job is started. A monitor
// pops and compares them on each done pulse. The main sequence checks busy
// length, done latency, the single-cycle done pulse, p hold, an ignored start
// during RUN, reset in the middle of a job, and back-to-back jobs.
// -----------------------------------------------------------------------------
module tb_radix4_serial_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic        start8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        busy8;
  logic        done8;
  logic [15:0] p8;
  logic        start4;
  logic [3:0]  a4;
  logic [3:0]  b4;
  logic        busy4;
  logic        done4;
  logic [7:0]  p4;

  int checks   = 0;
  int failures = 0;
  logic [15:0] q8[$];
  logic [7:0]  q4[$];

  radix4_serial_multiplier #(.N(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .p(p8)
  );

  radix4_serial_multiplier #(.N(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .p(p4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: on each done pulse, pop the oldest expected product and compare it with p.
  always @(posedge clk) begin
    #1;
    if (done8 === 1'b1) begin
      checks++;
      assert (q8.size() > 0) else begin
        failures++;
        $error("FAIL sb8_unexpected_done observed=done expected=no_done p=0x%0h", p8);
      end
      if (q8.size() > 0) chk("p8_result", {16'h0, p8}, {16'h0, q8.pop_front()});
    end
    if (done4 === 1'b1) begin
      checks++;
      assert (q4.size() > 0) else begin
        failures++;
        $error("FAIL sb4_unexpected_done observed=done expected=no_done p=0x%0h", p4);
      end
      if (q4.size() > 0) chk("p4_result", {24'h0, p4}, {24'h0, q4.pop_front()});
    end
  end

  // Call at accept edge + 1. Measures busy cycles and done latency, then moves
  // one edge past done and checks that the pulse has ended.
  task automatic wait_done(input bit sel, input bit hold_en, input logic [15:0] hold_val,
                           input int exp_lat, input int exp_busy, input string tag);
    int  k = 1;
    int  busy_cnt = 0;
    int  lat = 0;
    bit  seen = 1'b0;
    logic bsy, dn;
    logic [15:0] pv;
    while (k <= 60 && !seen) begin
      bsy = sel ? busy4 : busy8;
      dn  = sel ? done4 : done8;
      pv  = sel ? {8'h0, p4} : p8;
      if (dn === 1'b1) begin
        seen = 1'b1;
        lat  = k;
        chk({tag, "_busy_at_done"}, {31'h0, bsy}, 32'd0);
      end else begin
        if (bsy === 1'b1) busy_cnt++;
        if (hold_en) chk({tag, "_p_hold"}, {16'h0, pv}, {16'h0, hold_val});
        @(posedge clk); #1;
        k++;
      end
    end
    chk({tag, "_done_seen"}, {31'h0, seen}, 32'd1);
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_busy_cycles"}, busy_cnt, exp_busy);
    @(posedge clk); #1;
    chk({tag, "_done_one_cycle"}, {31'h0, (sel ? done4 : done8)}, 32'd0);
  endtask

  // Present a request to the N=8 instance; returns at accept edge + 1 with start low.
  task automatic go8(input logic [7:0] av, input logic [7:0] bv, input logic [15:0] exp, input bit push);
    start8 = 1'b1; a8 = av; b8 = bv;
    if (push) q8.push_back(exp);
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
  endtask

  initial begin
    int dcnt;
    rst = 1'b1; start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    start4 = 1'b0; a4 = 4'h0; b4 = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_busy8", {31'h0, busy8}, 32'd0);
    chk("rst_done8", {31'h0, done8}, 32'd0);
    chk("rst_p8", {16'h0, p8}, 32'd0);
    chk("rst_busy4", {31'h0, busy4}, 32'd0);
    chk("rst_done4", {31'h0, done4}, 32'd0);
    chk("rst_p4", {24'h0, p4}, 32'd0);
    @(posedge clk); #1;

    // Maximum operands.
    go8(8'hFF, 8'hFF, 16'hFE01, 1'b1);
    wait_done(1'b0, 1'b0, 16'h0, 17, 16, "ffxff");

    // A5 x 3C, then 00 x 7F; p must hold 26AC until the second job completes.
    go8(8'hA5, 8'h3C, 16'h26AC, 1'b1);
    wait_done(1'b0, 1'b0, 16'h0, 17, 16, "a5x3c");
    @(posedge clk); #1;
    chk("idle_p_hold", {16'h0, p8}, 32'h26AC);
    go8(8'h00, 8'h7F, 16'h0000, 1'b1);
    wait_done(1'b0, 1'b1, 16'h26AC, 17, 16, "00x7f");

    // A start pulse in the 3rd RUN cycle must be ignored.
    go8(8'h0F, 8'h0F, 16'h00E1, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    start8 = 1'b1; a8 = 8'h12; b8 = 8'h34;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    dcnt = 0;
    for (int c = 0; c < 30; c++) begin
      if (done8 === 1'b1) dcnt++;
      @(posedge clk); #1;
    end
    chk("ignored_start_done_count", dcnt, 1);
    chk("ignored_start_idle", {31'h0, busy8}, 32'd0);

    // Reset in the 6th RUN cycle discards the job.
    go8(8'hFF, 8'hFF, 16'h0, 1'b0);
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_busy", {31'h0, busy8}, 32'd0);
    chk("midrst_done", {31'h0, done8}, 32'd0);
    chk("midrst_p", {16'h0, p8}, 32'd0);
    dcnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (done8 === 1'b1 || busy8 === 1'b1) dcnt++;
      @(posedge clk); #1;
    end
    chk("midrst_stays_idle", dcnt, 0);
    go8(8'h03, 8'h05, 16'h000F, 1'b1);
    wait_done(1'b0, 1'b0, 16'h0, 17, 16, "03x05");

    // Start held high: two back-to-back jobs, with done pulses 17 cycles apart.
    start8 = 1'b1; a8 = 8'h10; b8 = 8'h10;
    q8.push_back(16'h0100);
    @(posedge clk); #1;
    a8 = 8'h02; b8 = 8'h80;
    q8.push_back(16'h0100);
    wait_done(1'b0, 1'b0, 16'h0, 17, 16, "b2b_first");
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    wait_done(1'b0, 1'b0, 16'h0, 17, 16, "b2b_second");

    // N=4 instance.
    start4 = 1'b1; a4 = 4'hF; b4 = 4'hF; q4.push_back(8'hE1);
    @(posedge clk); #1;
    start4 = 1'b0;
    wait_done(1'b1, 1'b0, 16'h0, 5, 4, "n4_fxf");
    start4 = 1'b1; a4 = 4'h9; b4 = 4'h6; q4.push_back(8'h36);
    @(posedge clk); #1;
    start4 = 1'b0;
    wait_done(1'b1, 1'b0, 16'h0, 5, 4, "n4_9x6");

    repeat (3) @(posedge clk);
    #1;
    chk("sb8_drained", q8.size(), 0);
    chk("sb4_drained", q4.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
